// File: rtl/ibex_mem_pkg.sv
// Shared types and helpers for the instruction-side memory responder.
// Response entries carry the snapshot taken at grant time plus an age.
package ibex_mem_pkg;

  localparam int unsigned DefRespLatency    = 1;
  localparam int unsigned DefMaxOutstanding = 2;
  localparam int unsigned AgeW              = 8;

  typedef struct packed {
    logic [31:0]     rdata;
    logic            err;
    logic [AgeW-1:0] age;
  } instr_resp_entry_t;

  // Out of range below base, past the array end, or inside the error window
  function automatic logic addr_err(
    input logic [31:0] addr,
    input logic [31:0] base,
    input logic [31:0] words,
    input logic [31:0] eb,
    input logic [31:0] el
  );
    logic [31:0] off;
    off = addr - base;
    return (addr < base) ||
           ((off >> 2) >= words) ||
           ((eb <= el) && (addr >= eb) && (addr <= el));
  endfunction

endpackage

// File: rtl/ibex_resp_fifo.sv
// In-order response queue with per-entry ageing.
// The head is presented once it has aged RespLatency cycles.
module ibex_resp_fifo
  import ibex_mem_pkg::*;
#(
  parameter int unsigned Depth       = DefMaxOutstanding,
  parameter int unsigned RespLatency = DefRespLatency,
  localparam int unsigned CW         = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_push,
  input  instr_resp_entry_t i_entry,
  input  logic              i_pop,
  output logic [31:0]       o_rdata,
  output logic              o_err,
  output logic              o_head_ready,
  output logic [CW-1:0]     o_count
);

  instr_resp_entry_t r_q [Depth];
  logic [CW-1:0]     r_count;

  instr_resp_entry_t w_q [Depth];
  logic [CW-1:0]     w_wr;
  logic [CW-1:0]     w_count;

  always_comb begin
    w_q = r_q;
    for (int i = 0; i < Depth; i++) begin
      if (CW'(i) < r_count &&
          r_q[i].age < AgeW'(RespLatency)) begin
        w_q[i].age = r_q[i].age + AgeW'(1);
      end
    end
    if (i_pop) begin
      for (int i = 0; i < Depth - 1; i++) begin
        w_q[i] = w_q[i+1];
      end
    end
    w_wr = i_pop ? r_count - CW'(1) : r_count;
    if (i_push && (int'(w_wr) < Depth)) begin
      w_q[w_wr] = i_entry;
    end
    w_count = r_count + CW'(i_push) - CW'(i_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
      for (int i = 0; i < Depth; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      r_count <= w_count;
      for (int i = 0; i < Depth; i++) begin
        r_q[i] <= w_q[i];
      end
    end
  end

  assign o_head_ready = (r_count != '0) &&
                        (r_q[0].age == AgeW'(RespLatency));
  assign o_rdata      = r_q[0].rdata;
  assign o_err        = r_q[0].err;
  assign o_count      = r_count;

endmodule

// File: rtl/ibex_instr_mem_responder.sv
// Slave end of the instruction fetch bus: word array, grant
// throttling, error decode and fixed-latency in-order responses.
module ibex_instr_mem_responder
  import ibex_mem_pkg::*;
#(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] AddrBase       = 32'h0000_0000,
  parameter int unsigned RespLatency    = DefRespLatency,
  parameter int unsigned MaxOutstanding = DefMaxOutstanding,
  parameter logic [31:0] ErrBase        = 32'hFFFF_FFFF,
  parameter logic [31:0] ErrLimit       = 32'hFFFF_FFFF,
  localparam int unsigned AW            = $clog2(MemWords),
  localparam int unsigned CW            = $clog2(MaxOutstanding + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  input  logic          stall_gnt_i,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [31:0]   load_wdata_i,
  output logic [CW-1:0] outstanding_o
);

  logic [31:0] r_mem [MemWords];

  logic [AW-1:0]     w_idx;
  logic              w_err;
  logic              w_push;
  logic              w_retire;
  logic              w_head_ready;
  logic [31:0]       w_head_rdata;
  logic              w_head_err;
  logic [CW-1:0]     w_count;
  instr_resp_entry_t w_entry;

  assign w_idx = AW'((instr_addr_i - AddrBase) >> 2);
  assign w_err = addr_err(instr_addr_i, AddrBase,
                          32'(MemWords), ErrBase, ErrLimit);

  assign w_retire    = w_head_ready;
  assign instr_gnt_o = instr_req_i & ~stall_gnt_i &
                       ((w_count < CW'(MaxOutstanding)) | w_retire);
  assign w_push      = instr_req_i & instr_gnt_o;

  // Snapshot is taken before any same-edge sideband write lands
  assign w_entry.rdata = w_err ? 32'h0 : r_mem[w_idx];
  assign w_entry.err   = w_err;
  assign w_entry.age   = AgeW'(1);

  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      r_mem[load_addr_i] <= load_wdata_i;
    end
  end

  ibex_resp_fifo #(
    .Depth      (MaxOutstanding),
    .RespLatency(RespLatency)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_push      (w_push),
    .i_entry     (w_entry),
    .i_pop       (w_retire),
    .o_rdata     (w_head_rdata),
    .o_err       (w_head_err),
    .o_head_ready(w_head_ready),
    .o_count     (w_count)
  );

  assign instr_rvalid_o = w_head_ready;
  assign instr_rdata_o  = w_head_ready ? w_head_rdata : 32'h0;
  assign instr_err_o    = w_head_ready & w_head_err;
  assign outstanding_o  = w_count;

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Directed bench for the instruction memory responder.
// Three instances cover latency 1, 3 and 2 configurations.
module tb_ibex_instr_mem_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall, load_we;
  logic [9:0]  load_addr;
  logic [31:0] load_wdata;

  logic        a_req, a_gnt, a_rv, a_err;
  logic [31:0] a_addr, a_rdata;
  logic [1:0]  a_out;
  logic        b_req, b_gnt, b_rv, b_err;
  logic [31:0] b_addr, b_rdata;
  logic [1:0]  b_out;
  logic        c_req, c_gnt, c_rv, c_err;
  logic [31:0] c_addr, c_rdata;
  logic [1:0]  c_out;

  int errors = 0;
  int checks = 0;

  ibex_instr_mem_responder #(
    .RespLatency(1), .MaxOutstanding(2),
    .ErrBase(32'h100), .ErrLimit(32'h1FF)
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(a_req), .instr_addr_i(a_addr),
    .instr_gnt_o(a_gnt), .instr_rvalid_o(a_rv),
    .instr_rdata_o(a_rdata), .instr_err_o(a_err),
    .stall_gnt_i(stall), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .outstanding_o(a_out)
  );

  ibex_instr_mem_responder #(
    .RespLatency(3), .MaxOutstanding(2)
  ) u_b (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(b_req), .instr_addr_i(b_addr),
    .instr_gnt_o(b_gnt), .instr_rvalid_o(b_rv),
    .instr_rdata_o(b_rdata), .instr_err_o(b_err),
    .stall_gnt_i(1'b0), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .outstanding_o(b_out)
  );

  ibex_instr_mem_responder #(
    .RespLatency(2), .MaxOutstanding(2)
  ) u_c (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(c_req), .instr_addr_i(c_addr),
    .instr_gnt_o(c_gnt), .instr_rvalid_o(c_rv),
    .instr_rdata_o(c_rdata), .instr_err_o(c_err),
    .stall_gnt_i(1'b0), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_wdata_i(load_wdata),
    .outstanding_o(c_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    load_we    = 1'b1;
    load_addr  = 10'(idx);
    load_wdata = d;
    step();
    load_we = 1'b0;
  endtask

  task automatic fetch_a(input string tag,
                         input logic [31:0] addr,
                         input logic        e_err,
                         input logic        do_data,
                         input logic [31:0] e_data);
    a_req  = 1'b1;
    a_addr = addr;
    #1;
    chk({tag, "_gnt"}, 32'(a_gnt), 32'd1);
    step();
    a_req = 1'b0;
    #1;
    chk({tag, "_rv"}, 32'(a_rv), 32'd1);
    chk({tag, "_err"}, 32'(a_err), 32'(e_err));
    if (do_data) chk({tag, "_data"}, a_rdata, e_data);
    step();
    chk({tag, "_rv_off"}, 32'(a_rv), 32'd0);
  endtask

  logic [31:0] prog [4] = '{32'h00000013, 32'h00100093,
                            32'h00200113, 32'h00300193};
  bit eg [9] = '{1, 1, 0, 1, 1, 0, 1, 1, 0};
  bit er [9] = '{0, 0, 0, 1, 1, 0, 1, 1, 0};
  bit ed [3] = '{1, 1, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stall = 0; load_we = 0; load_addr = '0; load_wdata = '0;
    a_req = 0; a_addr = '0;
    b_req = 0; b_addr = '0;
    c_req = 0; c_addr = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_rv", 32'({a_rv, b_rv, c_rv}), 32'd0);
    chk("rst_err", 32'({a_err, b_err, c_err}), 32'd0);
    chk("rst_data", a_rdata | b_rdata | c_rdata, 32'd0);
    chk("rst_out", 32'({a_out, b_out, c_out}), 32'd0);

    for (int i = 0; i < 4; i++) load(i, prog[i]);
    load(4, 32'h12345678);
    load(32'h80, 32'hCAFEF00D);

    // Back-to-back fetch at latency 1
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        a_req  = 1'b1;
        a_addr = 32'(4 * i);
      end else begin
        a_req = 1'b0;
      end
      #1;
      if (i < 4) chk("b2b_gnt", 32'(a_gnt), 32'd1);
      if (i > 0) begin
        chk("b2b_rv", 32'(a_rv), 32'd1);
        chk("b2b_data", a_rdata, prog[i-1]);
      end else begin
        chk("b2b_rv0", 32'(a_rv), 32'd0);
      end
      chk("b2b_out", 32'(a_out <= 2'd1), 32'd1);
      step();
    end
    chk("b2b_idle", 32'(a_rv), 32'd0);

    // Outstanding limit at latency 3
    b_req  = 1'b1;
    b_addr = 32'h0;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("lim_gnt%0d", i), 32'(b_gnt), 32'(eg[i]));
      chk($sformatf("lim_rv%0d", i), 32'(b_rv), 32'(er[i]));
      if (er[i]) chk("lim_data", b_rdata, prog[0]);
      chk("lim_out", 32'(b_out <= 2'd2), 32'd1);
      step();
    end
    b_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("drain_rv%0d", i), 32'(b_rv), 32'(ed[i]));
      step();
    end
    chk("drain_out", 32'(b_out), 32'd0);

    // Error window and range decode
    fetch_a("err_win_lo", 32'h100, 1'b1, 1'b1, 32'h0);
    fetch_a("err_win_hi", 32'h1FC, 1'b1, 1'b1, 32'h0);
    fetch_a("err_after", 32'h200, 1'b0, 1'b1, 32'hCAFEF00D);
    fetch_a("err_range", 32'h1000, 1'b1, 1'b1, 32'h0);
    fetch_a("unaligned", 32'h7, 1'b0, 1'b1, prog[1]);

    // Stall then read-before-write hazard
    stall  = 1'b1;
    a_req  = 1'b1;
    a_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_gnt", 32'(a_gnt), 32'd0);
      chk("stall_rv", 32'(a_rv), 32'd0);
      chk("stall_out", 32'(a_out), 32'd0);
      step();
    end
    stall      = 1'b0;
    load_we    = 1'b1;
    load_addr  = 10'd4;
    load_wdata = 32'hDEADBEEF;
    #1;
    chk("haz_gnt", 32'(a_gnt), 32'd1);
    step();
    load_we = 1'b0;
    a_req   = 1'b0;
    #1;
    chk("haz_rv", 32'(a_rv), 32'd1);
    chk("haz_old", a_rdata, 32'h12345678);
    step();
    fetch_a("haz_new", 32'h10, 1'b0, 1'b1, 32'hDEADBEEF);

    // Reset with two requests in flight at latency 2
    c_req  = 1'b1;
    c_addr = 32'h0;
    #1;
    chk("rst_g0", 32'(c_gnt), 32'd1);
    step();
    #1;
    chk("rst_g1", 32'(c_gnt), 32'd1);
    chk("rst_rv_pre", 32'(c_rv), 32'd0);
    step();
    c_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rv", 32'(c_rv), 32'd0);
    chk("rst_mid_out", 32'(c_out), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst_rv", 32'(c_rv), 32'd0);
      chk("post_rst_out", 32'(c_out), 32'd0);
      step();
    end
    c_req  = 1'b1;
    c_addr = 32'h4;
    #1;
    chk("new_gnt", 32'(c_gnt), 32'd1);
    step();
    c_req = 1'b0;
    #1;
    chk("new_rv1", 32'(c_rv), 32'd0);
    step();
    chk("new_rv2", 32'(c_rv), 32'd1);
    chk("new_data", c_rdata, prog[1]);
    step();
    chk("new_rv3", 32'(c_rv), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
